// File: rtl/db_pkg.sv
// Shared command codes, FSM states and reply words for the UART debug controller.
package db_pkg;

  typedef enum logic [3:0] {
    CMD_NONE   = 4'd0,
    CMD_PAUSE  = 4'd1,
    CMD_RESUME = 4'd2,
    CMD_RESET  = 4'd3,
    CMD_STATUS = 4'd4,
    CMD_MEM_RD = 4'd5,
    CMD_MEM_WR = 4'd6,
    CMD_REG_RD = 4'd7,
    CMD_REG_WR = 4'd8,
    CMD_BP_ADD = 4'd9,
    CMD_BP_RM  = 4'd10
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ACCESS,
    ST_MEM_WAIT,
    ST_REPLY
  } state_t;

  localparam logic [31:0] REPLY_ERR  = 32'hFFFF_FFFF;
  localparam logic [31:0] REPLY_OK   = 32'd0;
  localparam logic [31:0] REPLY_FAIL = 32'd1;

  // Commands that must see the core halted before they can complete.
  function automatic logic needs_halt(input logic [3:0] c);
    return (c == CMD_PAUSE)  || (c == CMD_MEM_RD) || (c == CMD_MEM_WR) ||
           (c == CMD_REG_RD) || (c == CMD_REG_WR);
  endfunction

endpackage

// File: rtl/debug_controller_if.sv
// Command channel between serial_driver (master) and debug_controller (slave):
// one command per out_valid pulse, ctrlr_busy held until the reply word lands on d_rd.
interface debug_controller_if;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        out_valid;
  logic        ctrlr_busy;
  logic [31:0] d_rd;

  modport master (output cmd, addr, d_in, out_valid, input ctrlr_busy, d_rd);
  modport slave  (input cmd, addr, d_in, out_valid, output ctrlr_busy, d_rd);
endinterface

// File: rtl/bp_table.sv
// Hardware breakpoint table: add fills the lowest free slot, remove clears every equal slot.
// Table updates land on the clock edge; full/found/match are combinational.
module bp_table #(
  parameter int NUM_BP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_vld,
  input  logic        rm_vld,
  input  logic [31:0] op_addr,
  input  logic [31:0] pc,
  output logic        full,
  output logic        found,
  output logic        match
);

  logic [NUM_BP-1:0] valid;
  logic [31:0]       bp_addr [NUM_BP];
  logic [NUM_BP-1:0] free_onehot;
  logic [NUM_BP-1:0] hit_op;
  logic [NUM_BP-1:0] hit_pc;

  always_comb begin
    // Isolates the lowest clear bit of valid; all zeros when the table is full.
    free_onehot = ~valid & (valid + NUM_BP'(1));
    hit_op      = '0;
    hit_pc      = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_op[i] = valid[i] && (bp_addr[i] == op_addr);
      hit_pc[i] = valid[i] && (bp_addr[i] == pc);
    end
  end

  assign full  = &valid;
  assign found = |hit_op;
  assign match = |hit_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (add_vld && !full) begin
      valid <= valid | free_onehot;
    end else if (rm_vld) begin
      valid <= valid & ~hit_op;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BP; i++) begin
      if (add_vld && free_onehot[i]) begin
        bp_addr[i] <= op_addr;
      end
    end
  end

endmodule

// File: rtl/debug_controller.sv
// Debug sequencer: halts the MCU, performs memory/register accesses, returns one reply word.
// Reply 2 cycles after out_valid for local commands, longer when a halt/access is needed; out_valid while busy is dropped.
module debug_controller
  import db_pkg::*;
#(
  parameter int NUM_BP       = 8,
  parameter int MEM_LAT      = 2,
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  debug_controller_if.slave host,
  output logic              mcu_pause,
  input  logic              mcu_paused,
  output logic              mcu_reset,
  input  logic [31:0]       mcu_pc,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic [4:0]        rf_addr,
  output logic              rf_we,
  output logic [31:0]       rf_din,
  input  logic [31:0]       rf_dout
);

  localparam int HW = $clog2(HALT_TIMEOUT + 1);
  localparam int MW = $clog2(MEM_LAT + 1);

  state_t        state;
  logic [3:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [31:0]   din_q;
  logic [31:0]   reply_q;
  logic [31:0]   d_rd_q;
  logic [31:0]   mask_pc;
  logic [HW-1:0] hcnt;
  logic [MW-1:0] mcnt;
  logic          busy_q;
  logic          was_running;
  logic          bp_hit;
  logic          mask_vld;
  logic          bp_add;
  logic          bp_rm;
  logic          bp_full;
  logic          bp_found;
  logic          bp_match;
  logic          bp_trip;

  assign host.ctrlr_busy = busy_q;
  assign host.d_rd       = d_rd_q;

  assign bp_add  = (state == ST_REPLY) && (cmd_q == CMD_BP_ADD);
  assign bp_rm   = (state == ST_REPLY) && (cmd_q == CMD_BP_RM);
  // The PC latched at RESUME is ignored until the core moves off it.
  assign bp_trip = !mcu_pause && bp_match && !(mask_vld && (mcu_pc == mask_pc));

  bp_table #(.NUM_BP(NUM_BP)) u_bp_table (
    .clk     (clk),
    .reset   (reset),
    .add_vld (bp_add),
    .rm_vld  (bp_rm),
    .op_addr (addr_q),
    .pc      (mcu_pc),
    .full    (bp_full),
    .found   (bp_found),
    .match   (bp_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      reply_q     <= '0;
      d_rd_q      <= '0;
      mask_pc     <= '0;
      hcnt        <= '0;
      mcnt        <= '0;
      busy_q      <= 1'b0;
      was_running <= 1'b0;
      bp_hit      <= 1'b0;
      mask_vld    <= 1'b0;
      mcu_pause   <= 1'b0;
      mcu_reset   <= 1'b0;
      mem_rd      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      rf_addr     <= '0;
      rf_we       <= 1'b0;
      rf_din      <= '0;
    end else begin
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      rf_we     <= 1'b0;
      mcu_reset <= 1'b0;

      if (mask_vld && (mcu_pc != mask_pc)) mask_vld <= 1'b0;
      if (bp_trip) begin
        mcu_pause <= 1'b1;
        bp_hit    <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (host.out_valid && (host.cmd != CMD_NONE)) begin
            cmd_q       <= host.cmd;
            addr_q      <= host.addr;
            din_q       <= host.d_in;
            busy_q      <= 1'b1;
            hcnt        <= '0;
            was_running <= !mcu_pause;
            if (needs_halt(host.cmd)) begin
              mcu_pause <= 1'b1;
              state     <= ST_HALT;
            end else begin
              state <= ST_REPLY;
            end
          end
        end

        ST_HALT: begin
          if (mcu_paused) begin
            if (cmd_q == CMD_PAUSE) begin
              reply_q <= REPLY_OK;
              state   <= ST_REPLY;
            end else begin
              // Set early so the async register-file read is settled in ACCESS.
              rf_addr <= addr_q[4:0];
              state   <= ST_ACCESS;
            end
          end else if (hcnt == HW'(HALT_TIMEOUT - 1)) begin
            if (was_running) mcu_pause <= 1'b0;
            reply_q <= REPLY_ERR;
            state   <= ST_REPLY;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end

        ST_ACCESS: begin
          state <= ST_REPLY;
          case (cmd_q)
            CMD_MEM_RD: begin
              mem_rd   <= 1'b1;
              mem_addr <= addr_q;
              mcnt     <= '0;
              state    <= ST_MEM_WAIT;
            end
            CMD_MEM_WR: begin
              mem_we   <= 1'b1;
              mem_addr <= addr_q;
              mem_din  <= din_q;
              reply_q  <= REPLY_OK;
            end
            CMD_REG_RD: reply_q <= rf_dout;
            CMD_REG_WR: begin
              rf_we   <= 1'b1;
              rf_din  <= din_q;
              reply_q <= REPLY_OK;
            end
            default: reply_q <= REPLY_ERR;
          endcase
        end

        ST_MEM_WAIT: begin
          if (mcnt == MW'(MEM_LAT - 1)) begin
            reply_q <= mem_dout;
            state   <= ST_REPLY;
          end else begin
            mcnt <= mcnt + MW'(1);
          end
        end

        ST_REPLY: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
          case (cmd_q)
            CMD_RESUME: begin
              mcu_pause <= 1'b0;
              mask_vld  <= 1'b1;
              mask_pc   <= mcu_pc;
              d_rd_q    <= REPLY_OK;
            end
            CMD_RESET: begin
              mcu_reset <= 1'b1;
              bp_hit    <= 1'b0;
              d_rd_q    <= REPLY_OK;
            end
            CMD_STATUS: d_rd_q <= {29'b0, bp_full, bp_hit, mcu_paused};
            CMD_BP_ADD: d_rd_q <= bp_full ? REPLY_FAIL : REPLY_OK;
            CMD_BP_RM:  d_rd_q <= bp_found ? REPLY_OK : REPLY_FAIL;
            CMD_PAUSE, CMD_MEM_RD, CMD_MEM_WR, CMD_REG_RD, CMD_REG_WR:
              d_rd_q <= reply_q;
            default: d_rd_q <= REPLY_ERR;
          endcase
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller with MCU core, memory and register-file models.
module tb_debug_controller;
  import db_pkg::*;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mcu_pause;
  logic        mcu_paused = 1'b0;
  logic        mcu_reset;
  logic [31:0] mcu_pc = 32'd0;
  logic        mem_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'd0;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_din;
  logic [31:0] rf_dout;

  logic [31:0] mem [256];
  logic [31:0] rf  [32];
  bit          no_ack = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          mem_we_cnt = 0;
  int          mem_rd_cnt = 0;
  int          rf_we_cnt = 0;
  int          mcu_reset_cnt = 0;
  logic [31:0] last_we_addr = 32'd0;
  logic [31:0] last_we_data = 32'd0;
  int          lat;
  int          n;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  debug_controller_if dbg ();

  debug_controller #(
    .NUM_BP       (8),
    .MEM_LAT      (MEM_LAT),
    .HALT_TIMEOUT (1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (dbg),
    .mcu_pause  (mcu_pause),
    .mcu_paused (mcu_paused),
    .mcu_reset  (mcu_reset),
    .mcu_pc     (mcu_pc),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .rf_addr    (rf_addr),
    .rf_we      (rf_we),
    .rf_din     (rf_din),
    .rf_dout    (rf_dout)
  );

  always #5 clk = ~clk;

  // Core acknowledges a halt one cycle later; memory read data is registered.
  always @(posedge clk) begin
    mcu_paused <= mcu_pause && !no_ack;
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else begin
      if (mem_we) begin
        mem[mem_addr[9:2]] <= mem_din;
        mem_we_cnt   <= mem_we_cnt + 1;
        last_we_addr <= mem_addr;
        last_we_data <= mem_din;
      end
      if (mem_rd) begin
        mem_dout   <= mem[mem_addr[9:2]];
        mem_rd_cnt <= mem_rd_cnt + 1;
      end
      if (rf_we) begin
        if (rf_addr != 5'd0) rf[rf_addr] <= rf_din;
        rf_we_cnt <= rf_we_cnt + 1;
      end
      if (mcu_reset) mcu_reset_cnt <= mcu_reset_cnt + 1;
    end
  end

  assign rf_dout = rf[rf_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                      input string tag, input logic [31:0] expd, input int elat);
    exp_t e;
    e.tag  = tag;
    e.data = expd;
    e.lat  = elat;
    exp_q.push_back(e);
    @(negedge clk);
    dbg.cmd       = c;
    dbg.addr      = a;
    dbg.d_in      = d;
    dbg.out_valid = 1'b1;
    @(negedge clk);
    dbg.out_valid = 1'b0;
    dbg.cmd       = CMD_NONE;
  endtask

  // Called one cycle after out_valid was sampled; optionally fires a STATUS while busy.
  task automatic await_reply(input bit poke);
    exp_t e;
    int   cyc;
    check("busy_rise", 32'(dbg.ctrlr_busy), 32'd1);
    cyc = 1;
    if (poke) begin
      dbg.cmd       = CMD_STATUS;
      dbg.out_valid = 1'b1;
    end
    while (dbg.ctrlr_busy === 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      dbg.out_valid = 1'b0;
      dbg.cmd       = CMD_NONE;
    end
    dbg.out_valid = 1'b0;
    e = exp_q.pop_front();
    check({e.tag, "_done"}, 32'(dbg.ctrlr_busy), 32'd0);
    check(e.tag, dbg.d_rd, e.data);
    if (e.lat > 0) check({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
    lat = cyc;
  endtask

  initial begin
    dbg.cmd       = CMD_NONE;
    dbg.addr      = 32'd0;
    dbg.d_in      = 32'd0;
    dbg.out_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({dbg.ctrlr_busy, mcu_pause, mcu_reset, mem_rd, mem_we, rf_we}), 32'd0);
    check("rst_d_rd", dbg.d_rd, 32'd0);
    check("rst_bus", mem_addr | mem_din | rf_din | 32'(rf_addr), 32'd0);
    reset = 1'b0;

    send(CMD_STATUS, 32'd0, 32'd0, "status_rst", REPLY_OK, 2);
    await_reply(1'b0);

    // Halt never acknowledged
    no_ack = 1'b1;
    send(CMD_PAUSE, 32'd0, 32'd0, "halt_tmo", REPLY_ERR, 0);
    await_reply(1'b0);
    check("tmo_lat_ge", 32'(lat >= 1024), 32'd1);
    check("tmo_unpause", 32'(mcu_pause), 32'd0);
    no_ack = 1'b0;

    send(CMD_MEM_WR, 32'h100, 32'hCAFE_BABE, "mem_wr", REPLY_OK, 0);
    await_reply(1'b0);
    check("mem_wr_halted", 32'(mcu_pause), 32'd1);
    check("mem_we_pulses", 32'(mem_we_cnt), 32'd1);
    check("mem_we_addr", last_we_addr, 32'h100);
    check("mem_we_data", last_we_data, 32'hCAFE_BABE);

    send(CMD_MEM_RD, 32'h100, 32'd0, "mem_rd", 32'hCAFE_BABE, 4 + MEM_LAT);
    await_reply(1'b1);
    check("mem_rd_pulses", 32'(mem_rd_cnt), 32'd1);
    repeat (3) @(negedge clk);
    check("poke_ignored", 32'(dbg.ctrlr_busy), 32'd0);
    check("d_rd_hold", dbg.d_rd, 32'hCAFE_BABE);

    send(CMD_REG_WR, 32'd5, 32'h1234_5678, "reg_wr", REPLY_OK, 4);
    await_reply(1'b0);
    send(CMD_REG_RD, 32'd5, 32'd0, "reg_rd", 32'h1234_5678, 4);
    await_reply(1'b0);
    send(CMD_REG_WR, 32'd0, 32'h0000_DEAD, "reg_wr_x0", REPLY_OK, 4);
    await_reply(1'b0);
    check("rf_we_pulses", 32'(rf_we_cnt), 32'd2);
    send(CMD_REG_RD, 32'd0, 32'd0, "reg_rd_x0", 32'd0, 4);
    await_reply(1'b0);

    send(4'd12, 32'd0, 32'd0, "err_cmd", REPLY_ERR, 2);
    await_reply(1'b0);

    // Breakpoint hit and resume mask
    send(CMD_BP_ADD, 32'h40, 32'd0, "bp_add", REPLY_OK, 2);
    await_reply(1'b0);
    mcu_pc = 32'h3C;
    send(CMD_RESUME, 32'd0, 32'd0, "resume", REPLY_OK, 2);
    await_reply(1'b0);
    @(negedge clk);
    check("resume_run", 32'(mcu_pause), 32'd0);
    mcu_pc = 32'h40;
    @(negedge clk);
    check("bp_halt", 32'(mcu_pause), 32'd1);
    @(negedge clk);
    send(CMD_STATUS, 32'd0, 32'd0, "status_bp", 32'd3, 2);
    await_reply(1'b0);

    send(CMD_RESUME, 32'd0, 32'd0, "resume_at_bp", REPLY_OK, 2);
    await_reply(1'b0);
    repeat (3) @(negedge clk);
    check("mask_hold", 32'(mcu_pause), 32'd0);
    mcu_pc = 32'h44;
    @(negedge clk);
    mcu_pc = 32'h40;
    @(negedge clk);
    check("bp_rehalt", 32'(mcu_pause), 32'd1);

    send(CMD_RESET, 32'd0, 32'd0, "mcu_reset", REPLY_OK, 2);
    await_reply(1'b0);
    @(negedge clk);
    check("mcu_reset_pulses", 32'(mcu_reset_cnt), 32'd1);
    send(CMD_STATUS, 32'd0, 32'd0, "status_after_rst", 32'd1, 2);
    await_reply(1'b0);

    // Fill the table (slot 0 already holds 0x40)
    for (int i = 0; i < 7; i++) begin
      send(CMD_BP_ADD, 32'h1000 + 32'(i) * 32'd4, 32'd0, "bp_fill", REPLY_OK, 2);
      await_reply(1'b0);
    end
    send(CMD_BP_ADD, 32'h2000, 32'd0, "bp_add_full", REPLY_FAIL, 2);
    await_reply(1'b0);
    send(CMD_STATUS, 32'd0, 32'd0, "status_full", 32'd5, 2);
    await_reply(1'b0);
    send(CMD_BP_RM, 32'h999, 32'd0, "bp_rm_absent", REPLY_FAIL, 2);
    await_reply(1'b0);
    send(CMD_BP_RM, 32'h40, 32'd0, "bp_rm_present", REPLY_OK, 2);
    await_reply(1'b0);
    send(CMD_BP_ADD, 32'h2000, 32'd0, "bp_add_after_rm", REPLY_OK, 2);
    await_reply(1'b0);

    // Reset while waiting on memory read data
    @(negedge clk);
    dbg.cmd       = CMD_MEM_RD;
    dbg.addr      = 32'h100;
    dbg.out_valid = 1'b1;
    @(negedge clk);
    dbg.out_valid = 1'b0;
    dbg.cmd       = CMD_NONE;
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_mem_rd_seen", 32'(mem_rd), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ctl", 32'({dbg.ctrlr_busy, mcu_pause, mcu_reset, mem_rd, mem_we, rf_we}), 32'd0);
    check("abort_d_rd", dbg.d_rd, 32'd0);
    check("abort_bus", mem_addr | mem_din | rf_din | 32'(rf_addr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(CMD_STATUS, 32'd0, 32'd0, "status_after_abort", 32'd0, 2);
    await_reply(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
